// File: rtl/ddr3_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_arb_pkg
// Shared constants and types for the two-port DDR3 request arbiter.
//   - Port count and request field widths of the ddr3_axi_core inport.
//   - Default outstanding-request depth of the in-order tracking FIFO.
//   - Arbiter state record (grant / lock / last) and its reset value.
//   - is_request(): a port asks for service when any write strobe is set
//     or the read flag is raised.
// ---------------------------------------------------------------------------
package ddr3_arb_pkg;

    localparam int NUM_PORTS          = 2;
    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 128;
    localparam int STRB_W             = 16;
    localparam int ID_W               = 16;

    localparam int ARB_OUTSTANDING    = 4;
    localparam int ARB_OUTSTANDING_W  = 2;

    // LOCK_HELD means the granted port was presented to the core but not
    // yet accepted, so the grant must not move.
    typedef enum logic {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } lock_e;

    // Complete arbiter state; kept as one record so it can be observed as
    // a unit.
    typedef struct packed {
        logic  grant;   // port held while locked
        lock_e lock;    // grant frozen until the core accepts
        logic  last;    // port most recently accepted
    } arb_state_t;

    // last=1 so that port0 wins the first tie after reset.
    localparam arb_state_t ARB_STATE_RST = '{grant: 1'b0, lock: LOCK_OPEN, last: 1'b1};

    function automatic logic is_request(input logic [STRB_W-1:0] wr, input logic rd);
        return (|wr) | rd;
    endfunction

endpackage

// File: rtl/ddr3_arb_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_arb_fifo
// In-order tracking FIFO of 1-bit port indices. One entry is pushed for
// every request the core accepts and popped for every response, so the
// head always names the port that owns the next response.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   push           store push_port (ignored when full)
//   push_port      port index to store
//   pop            drop the head entry (ignored when empty)
//   full, empty    occupancy flags, derived from registered count only
//   head           port index at the read pointer
// Push and pop in the same cycle leave the count unchanged.
// ---------------------------------------------------------------------------
module ddr3_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic push_port,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_port;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_ram_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_ram_arbiter
// Shares the single ddr3_axi_core inport between two masters (for example
// the AXI-to-RAM bridge and a DMA/test engine).
//
// Handshake: a master requests by raising pN_rd_i or any pN_wr_i bit and
// holds every request field stable until it sees pN_accept_o high at a
// clock edge. The granted request is driven on ram_* (ram_wr_o/ram_rd_o
// are zero when nothing is issued); the transfer happens on the edge where
// issuing and ram_accept_i are both high. Responses arrive on ram_ack_i in
// request order and are steered to the owning port through a tracking FIFO.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   pN_wr_i/rd_i/addr_i/...       port N request fields (N = 0, 1)
//   pN_accept_o                   port N request taken this cycle
//   pN_ack_o / pN_error_o         port N response strobe / error
//   pN_read_data_o / resp_id_o    response payload (same on both ports)
//   ram_*_o                       request to ddr3_axi_core inport
//   ram_accept_i                  core took the request
//   ram_ack_i/error_i/...         core response
//
// Build option:
//   DDR3_ARB_FIXED_PRIO_EN  defined: port0 always wins ties (last port is
//                           ignored). Undefined: round-robin on ties.
// ---------------------------------------------------------------------------
module ddr3_ram_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int OUTSTANDING   = ARB_OUTSTANDING,
    parameter int OUTSTANDING_W = ARB_OUTSTANDING_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [STRB_W-1:0] p0_wr_i,
    input  logic              p0_rd_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_write_data_i,
    input  logic [ID_W-1:0]   p0_req_id_i,
    output logic              p0_accept_o,
    output logic              p0_ack_o,
    output logic              p0_error_o,
    output logic [DATA_W-1:0] p0_read_data_o,
    output logic [ID_W-1:0]   p0_resp_id_o,

    input  logic [STRB_W-1:0] p1_wr_i,
    input  logic              p1_rd_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_write_data_i,
    input  logic [ID_W-1:0]   p1_req_id_i,
    output logic              p1_accept_o,
    output logic              p1_ack_o,
    output logic              p1_error_o,
    output logic [DATA_W-1:0] p1_read_data_o,
    output logic [ID_W-1:0]   p1_resp_id_o,

    output logic [STRB_W-1:0] ram_wr_o,
    output logic              ram_rd_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_write_data_o,
    output logic [ID_W-1:0]   ram_req_id_o,
    input  logic              ram_accept_i,
    input  logic              ram_ack_i,
    input  logic              ram_error_i,
    input  logic [DATA_W-1:0] ram_read_data_i,
    input  logic [ID_W-1:0]   ram_resp_id_i
);

    logic [NUM_PORTS-1:0] req;
    arb_state_t           state_q;
    arb_state_t           state_d;
    logic                 tie_winner;
    logic                 grant;
    logic                 issuing;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_head;
    logic                 fifo_pop;

    assign req[0] = is_request(p0_wr_i, p0_rd_i);
    assign req[1] = is_request(p1_wr_i, p1_rd_i);

    // -----------------------------------------------------------------------
    // Grant selection (combinational, same cycle as the request).
    // -----------------------------------------------------------------------
`ifdef DDR3_ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    assign tie_winner = ~state_q.last;
`endif

    always_comb begin
        grant = 1'b0;
        if (state_q.lock == LOCK_HELD) begin
            grant = state_q.grant;
        end else if (req[0] && req[1]) begin
            grant = tie_winner;
        end else begin
            // Only port1, only port0, or nobody (grant then irrelevant).
            grant = req[1];
        end
    end

    // Full is registered, so a response in this cycle cannot enable an
    // issue in the same cycle. Reset suppresses issue so every output
    // reads zero while rst_i is low.
    assign issuing = rst_i & (grant ? req[1] : req[0]) & ~fifo_full;
    assign accept  = issuing & ram_accept_i;

    assign p0_accept_o = accept & ~grant;
    assign p1_accept_o = accept &  grant;

    // -----------------------------------------------------------------------
    // Request mux toward the core.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_wr_o         = '0;
        ram_rd_o         = 1'b0;
        ram_addr_o       = '0;
        ram_write_data_o = '0;
        ram_req_id_o     = '0;
        if (issuing) begin
            if (grant) begin
                ram_wr_o         = p1_wr_i;
                ram_rd_o         = p1_rd_i;
                ram_addr_o       = p1_addr_i;
                ram_write_data_o = p1_write_data_i;
                ram_req_id_o     = p1_req_id_i;
            end else begin
                ram_wr_o         = p0_wr_i;
                ram_rd_o         = p0_rd_i;
                ram_addr_o       = p0_addr_i;
                ram_write_data_o = p0_write_data_i;
                ram_req_id_o     = p0_req_id_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter state: register and next-state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_STATE_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d.last = grant;
            state_d.lock = LOCK_OPEN;
        end else if (issuing) begin
            // Presented but not taken: freeze the grant on this port.
            state_d.lock  = LOCK_HELD;
            state_d.grant = grant;
        end
    end

    // -----------------------------------------------------------------------
    // Response routing. Acks with nothing outstanding are dropped.
    // -----------------------------------------------------------------------
    ddr3_arb_fifo #(
        .DEPTH (OUTSTANDING),
        .PTR_W (OUTSTANDING_W)
    ) u_track (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (accept),
        .push_port (grant),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign fifo_pop = ram_ack_i & ~fifo_empty;

    assign p0_ack_o   = fifo_pop & ~fifo_head;
    assign p1_ack_o   = fifo_pop &  fifo_head;
    assign p0_error_o = ram_error_i & p0_ack_o;
    assign p1_error_o = ram_error_i & p1_ack_o;

    assign p0_read_data_o = rst_i ? ram_read_data_i : '0;
    assign p1_read_data_o = rst_i ? ram_read_data_i : '0;
    assign p0_resp_id_o   = rst_i ? ram_resp_id_i   : '0;
    assign p1_resp_id_o   = rst_i ? ram_resp_id_i   : '0;

endmodule
